des_tx_sched: RTL and testbench
===============================

DES_TX_SCHED -- requirements
Module: des_tx_sched

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 8, giving the number of bytes sent per 64-bit block (legal 1..8).
REQ-002 SHALL have port i_Clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_Rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports i_fReq0 / i_fReq1  in  1  block-send request from requester 0 / 1, level, held until acknowledged.
REQ-005 SHALL have ports i_Data0 / i_Data1  in  64  block payload of requester 0 / 1, valid while its request is high.
REQ-006 SHALL have ports o_fAck0 / o_fAck1  out  1  one-cycle pulse: payload captured, requester may drop request and change data.
REQ-007 SHALL have ports o_fSent0 / o_fSent1  out  1  one-cycle pulse: last byte of that requester's block has completed on the line.
REQ-008 SHALL have port o_fBusy  out  1  high in every state except IDLE.
REQ-009 SHALL have port o_fTx  out  1  byte-start strobe to the UART transmitter.
REQ-010 SHALL have port o_TxData  out  8  byte presented to the UART transmitter, stable from o_fTx until that byte's i_fDone.
REQ-011 SHALL have port i_fReady  in  1  UART transmitter idle and able to accept o_fTx.
REQ-012 SHALL have port i_fDone  in  1  UART transmitter one-cycle pulse at the end of a byte's stop bit.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT_DONE, DONE.
REQ-014 IDLE: if any request is high, SHALL grant one requester, capture its 64-bit payload into a shift register, pulse the matching o_fAck in the same cycle, clear the byte counter, and go to ISSUE.
REQ-015 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; with a single request that requester wins; the last-granted pointer SHALL update on every grant.
REQ-016 ISSUE: o_fTx SHALL be asserted combinationally only when i_fReady=1, for exactly that one cycle, with next state WAIT_DONE; while i_fReady=0 the block SHALL hold in ISSUE.
REQ-017 o_TxData SHALL be shift-register bits [63:56]; bytes SHALL go most-significant first.
REQ-018 WAIT_DONE: on i_fDone=1, if the byte counter equals NUM_BYTES-1 the next state SHALL be DONE; otherwise the counter SHALL increment, the shift register SHALL shift left by 8 with zero fill, and the next state SHALL be ISSUE.
REQ-019 DONE: SHALL pulse o_fSent of the granted requester for one cycle and return to IDLE; a new grant is possible on the following cycle.
REQ-020 i_fDone SHALL be ignored in IDLE, ISSUE and DONE; request inputs SHALL be ignored outside IDLE.
REQ-021 The byte counter SHALL be 3 bits and never wrap within a block.
REQ-022 o_fAck0/o_fAck1, and likewise o_fSent0/o_fSent1, SHALL never be high in the same cycle.

Reset
REQ-023 While i_Rst=1: state IDLE; counter, shift register and last-granted pointer 0 (requester 1 favoured next); o_fTx, o_fAck*, o_fSent* and o_fBusy 0; o_TxData 8'h00.
REQ-024 Reset mid-block SHALL abandon the block with no o_fSent pulse; the requester must re-request.

Structure
REQ-025 State encoding and the NUM_BYTES default SHALL live in the shared DES_Top package.
REQ-026 The two-input round-robin grant logic SHALL be the single sub-module des_tx_rr_arb.

Verification
REQ-027 Single send: req0 with 64'h0123456789ABCDEF and an ideal UART model -> ack0 the same cycle, o_TxData sequence 01,23,45,67,89,AB,CD,EF, then sent0 one cycle after the 8th i_fDone.
REQ-028 Contention: req0 and req1 rise in the same cycle after reset -> req1 is granted first, then req0; the third simultaneous pair grants req1 again.
REQ-029 Backpressure: i_fReady held 0 for 50 cycles in ISSUE -> o_fTx stays 0 and o_TxData is stable; o_fTx pulses exactly once in the cycle i_fReady rises.
REQ-030 Spurious i_fDone in IDLE and in ISSUE -> no counter change and no o_fSent pulse.
REQ-031 Reset after the 3rd byte is issued -> outputs at their reset values immediately, no sent pulse; a new req0 restarts from byte 63:56.
REQ-032 NUM_BYTES=2 with payload 64'hA5C3_xxxx -> bytes A5, C3 only, then sent.

Source files
------------

// File: rtl/des_top_pkg.sv
// Shared DES transmit types: scheduler state encoding and default block width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package DES_Top;

  localparam int NUM_BYTES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } tx_state_e;

endpackage

// File: rtl/des_tx_rr_arb.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
// Latency: grant is combinational, pointer updates on the granting edge.
// Backpressure: no grant while i_fEn is low.
module des_tx_rr_arb (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_fReq0,
  input  logic i_fReq1,
  input  logic i_fEn,
  output logic o_fGnt,
  output logic o_GntId
);

  // Reset value 0 means requester 0 was "last", so requester 1 is favoured first.
  logic last_id;

  always_comb begin
    o_fGnt = i_fEn & (i_fReq0 | i_fReq1);
    if (i_fReq0 & i_fReq1)
      o_GntId = ~last_id;
    else
      o_GntId = i_fReq1;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)
      last_id <= 1'b0;
    else if (o_fGnt)
      last_id <= o_GntId;
  end

endmodule

// File: rtl/des_tx_sched.sv
// Schedules 64-bit blocks from two requesters onto a byte UART, MSB byte first.
// Latency: ack in grant cycle, first strobe next cycle; sent one cycle after last done.
// Backpressure: holds in ISSUE while i_fReady is low; requests wait until IDLE.
module des_tx_sched
  import DES_Top::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_fReq0,
  input  logic        i_fReq1,
  input  logic [63:0] i_Data0,
  input  logic [63:0] i_Data1,
  output logic        o_fAck0,
  output logic        o_fAck1,
  output logic        o_fSent0,
  output logic        o_fSent1,
  output logic        o_fBusy,
  output logic        o_fTx,
  output logic [7:0]  o_TxData,
  input  logic        i_fReady,
  input  logic        i_fDone
);

  localparam logic [2:0] LAST_CNT = 3'(NUM_BYTES - 1);

  tx_state_e   state;
  logic [2:0]  byte_cnt;
  logic [63:0] shreg;
  logic        gnt_id;
  logic        arb_gnt;
  logic        arb_id;
  logic        arb_en;

  // Reset gates the grant so no ack can leak out while i_Rst is held.
  assign arb_en = (state == IDLE) & ~i_Rst;

  des_tx_rr_arb u_arb (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_fReq0 (i_fReq0),
    .i_fReq1 (i_fReq1),
    .i_fEn   (arb_en),
    .o_fGnt  (arb_gnt),
    .o_GntId (arb_id)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= IDLE;
      byte_cnt <= 3'd0;
      shreg    <= 64'd0;
      gnt_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_gnt) begin
            shreg    <= arb_id ? i_Data1 : i_Data0;
            gnt_id   <= arb_id;
            byte_cnt <= 3'd0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_fReady)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_fDone) begin
            if (byte_cnt == LAST_CNT) begin
              state <= DONE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              shreg    <= {shreg[55:0], 8'h00};
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_fAck0  = arb_gnt & ~arb_id;
  assign o_fAck1  = arb_gnt &  arb_id;
  assign o_fSent0 = (state == DONE) & ~gnt_id;
  assign o_fSent1 = (state == DONE) &  gnt_id;
  assign o_fBusy  = (state != IDLE);
  assign o_fTx    = (state == ISSUE) & i_fReady;
  assign o_TxData = shreg[63:56];

endmodule

// File: tb/tb_des_tx_sched.sv
// Directed bench for des_tx_sched: default 8-byte instance plus a 2-byte instance.
module tb_des_tx_sched;

  logic        clk;
  logic        rst;
  logic        req0, req1, ready, done;
  logic [63:0] data0, data1;
  logic        ack0, ack1, sent0, sent1, busy, tx;
  logic [7:0]  txd;

  logic        b_req0, b_req1, b_ready, b_done;
  logic [63:0] b_data0, b_data1;
  logic        b_ack0, b_ack1, b_sent0, b_sent1, b_busy, b_tx;
  logic [7:0]  b_txd;

  int checks = 0;
  int errors = 0;

  des_tx_sched dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_fReq0(req0), .i_fReq1(req1), .i_Data0(data0), .i_Data1(data1),
    .o_fAck0(ack0), .o_fAck1(ack1), .o_fSent0(sent0), .o_fSent1(sent1),
    .o_fBusy(busy), .o_fTx(tx), .o_TxData(txd),
    .i_fReady(ready), .i_fDone(done)
  );

  des_tx_sched #(.NUM_BYTES(2)) dut2 (
    .i_Clk(clk), .i_Rst(rst),
    .i_fReq0(b_req0), .i_fReq1(b_req1), .i_Data0(b_data0), .i_Data1(b_data1),
    .o_fAck0(b_ack0), .o_fAck1(b_ack1), .o_fSent0(b_sent0), .o_fSent1(b_sent1),
    .o_fBusy(b_busy), .o_fTx(b_tx), .o_TxData(b_txd),
    .i_fReady(b_ready), .i_fDone(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the strobe, checks the byte, then returns an i_fDone pulse.
  task automatic issue_byte(input logic [7:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("tx_strobe", tx, 1);
    chk("tx_data", txd, exp);
    step();
    chk("tx_one_cycle", tx, 0);
    repeat (2) step();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] d, input int nb, input logic id);
    for (int b = 0; b < nb; b++) begin
      issue_byte(d[63-8*b -: 8]);
      if (b < nb - 1) chk("no_early_sent", {sent1, sent0}, 0);
    end
    @(negedge clk);
    chk("sent", {sent1, sent0}, id ? 2'b10 : 2'b01);
    chk("busy_in_done", busy, 1);
    step();
    chk("sent_one_cycle", {sent1, sent0}, 0);
    chk("busy_back_idle", busy, 0);
  endtask

  task automatic do_block(input logic id, input logic [63:0] d);
    @(negedge clk);
    chk("ack", {ack1, ack0}, id ? 2'b10 : 2'b01);
    chk("busy_idle", busy, 0);
    step();
    if (id) req1 = 1'b0; else req0 = 1'b0;
    chk("busy_issue", busy, 1);
    send_bytes(d, 8, id);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; ready = 1'b1; done = 1'b0;
    data0 = '0; data1 = '0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_ready = 1'b1; b_done = 1'b0;
    b_data0 = '0; b_data1 = '0;

    // Reset values, including with a request pending during reset
    step(); step();
    req0 = 1'b1; data0 = 64'h0123456789ABCDEF;
    #1;
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx", tx, 0);
    chk("rst_txdata", txd, 8'h00);
    chk("rst_sent", {sent1, sent0}, 0);
    req0 = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Contention: req1 first, then req0, then req1 again on the next pair
    req0 = 1'b1; req1 = 1'b1;
    data0 = 64'h0123456789ABCDEF; data1 = 64'hFEDCBA9876543210;
    do_block(1'b1, 64'hFEDCBA9876543210);
    do_block(1'b0, 64'h0123456789ABCDEF);
    req0 = 1'b1; req1 = 1'b1;
    do_block(1'b1, 64'hFEDCBA9876543210);
    do_block(1'b0, 64'h0123456789ABCDEF);

    // Spurious done in IDLE
    done = 1'b1;
    @(negedge clk);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_sent", {sent1, sent0}, 0);
    step();
    done = 1'b0;
    chk("idle_done_stay", busy, 0);
    step();

    // Backpressure for 50 cycles, with a spurious done while held in ISSUE
    ready = 1'b0; req0 = 1'b1; data0 = 64'h1122334455667788;
    @(negedge clk);
    chk("bp_ack", {ack1, ack0}, 2'b01);
    step();
    req0 = 1'b0; data0 = 64'hDEADBEEFDEADBEEF;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_tx_low", tx, 0);
      chk("bp_data_stable", txd, 8'h11);
      chk("bp_no_sent", {sent1, sent0}, 0);
      if (i == 10) done = 1'b1;
      if (i == 11) done = 1'b0;
    end
    step();
    ready = 1'b1;
    send_bytes(64'h1122334455667788, 8, 1'b0);

    // Reset after the third byte is issued
    req0 = 1'b1; data0 = 64'h0011223344556677;
    @(negedge clk);
    chk("rb_ack", {ack1, ack0}, 2'b01);
    step();
    req0 = 1'b0;
    issue_byte(8'h00);
    issue_byte(8'h11);
    @(negedge clk);
    chk("rb_third_tx", tx, 1);
    chk("rb_third_data", txd, 8'h22);
    step();
    rst = 1'b1;
    #1;
    chk("rb_busy", busy, 0);
    chk("rb_tx", tx, 0);
    chk("rb_txdata", txd, 8'h00);
    chk("rb_sent", {sent1, sent0}, 0);
    step();
    chk("rb_sent_held", {sent1, sent0}, 0);
    rst = 1'b0;
    step();
    chk("rb_after_sent", {sent1, sent0}, 0);
    req0 = 1'b1;
    do_block(1'b0, 64'h0011223344556677);

    // NUM_BYTES=2 instance: only the top two bytes go out
    b_req0 = 1'b1; b_data0 = 64'hA5C3123456789ABC;
    @(negedge clk);
    chk("nb2_ack", {b_ack1, b_ack0}, 2'b01);
    step();
    b_req0 = 1'b0;
    @(negedge clk);
    chk("nb2_tx0", b_tx, 1);
    chk("nb2_byte0", b_txd, 8'hA5);
    step();
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    @(negedge clk);
    chk("nb2_tx1", b_tx, 1);
    chk("nb2_byte1", b_txd, 8'hC3);
    chk("nb2_no_early_sent", {b_sent1, b_sent0}, 0);
    step();
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    @(negedge clk);
    chk("nb2_sent", {b_sent1, b_sent0}, 2'b01);
    chk("nb2_busy_done", b_busy, 1);
    step();
    chk("nb2_sent_pulse", {b_sent1, b_sent0}, 0);
    chk("nb2_idle", b_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
